// File: rtl/scanout_pkg.sv
// Shared timing defaults, scan position type and helpers for the scanout path.
package scanout_pkg;

  // Default raster timing (cycles for horizontal, lines for vertical).
  localparam int H_ACTIVE_DEF = 16;
  localparam int H_FRONT_DEF  = 2;
  localparam int H_SYNC_DEF   = 4;
  localparam int H_BACK_DEF   = 2;
  localparam int V_ACTIVE_DEF = 16;
  localparam int V_FRONT_DEF  = 1;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 1;

  // Counter width; wide enough for any total up to 255.
  localparam int CNT_W = 8;

  // Both sync outputs are active-low.
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
  } scan_pos_t;

  // Line or frame total from its four timing segments.
  function automatic int total_of(input int active, input int front,
                                  input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/scanout_timing_gen.sv
// Raster position counters and stage-0 timing decode (active, syncs, strobes).
module scanout_timing_gen
  import scanout_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic active0,
  output logic hsync0,
  output logic vsync0,
  output logic origin0,
  output logic flip_point,
  output logic wrap
);

  localparam int H_TOTAL = total_of(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = total_of(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  scan_pos_t pos_r;

  // Advance the raster position: h wraps each line, v wraps each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_r <= '0;
    end else if (pos_r.h_cnt == H_LAST) begin
      pos_r.h_cnt <= '0;
      if (pos_r.v_cnt == V_LAST) begin
        pos_r.v_cnt <= '0;
      end else begin
        pos_r.v_cnt <= pos_r.v_cnt + CNT_W'(1);
      end
    end else begin
      pos_r.h_cnt <= pos_r.h_cnt + CNT_W'(1);
    end
  end

  assign active0    = (pos_r.h_cnt < H_VIS) && (pos_r.v_cnt < V_VIS);
  assign hsync0     = ((pos_r.h_cnt >= HS_START) && (pos_r.h_cnt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync0     = ((pos_r.v_cnt >= VS_START) && (pos_r.v_cnt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign origin0    = (pos_r.h_cnt == '0) && (pos_r.v_cnt == '0);
  // First cycle of the first blanking line: safe moment to swap buffers.
  assign flip_point = (pos_r.h_cnt == '0) && (pos_r.v_cnt == V_VIS);
  assign wrap       = (pos_r.h_cnt == H_LAST) && (pos_r.v_cnt == V_LAST);

endmodule

// File: rtl/framebuffer_scanout.sv
// Display scanout: raster-order SRAM reads, 1-cycle output alignment and
// tear-free buffer swap issued only in vertical blanking.
module framebuffer_scanout
  import scanout_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_ready,
  input  logic [DATA_SIZE-1:0] read_data,
  output logic [ADDR_SIZE-1:0] read_addr,
  output logic                 flip,
  output logic                 swap_done,
  output logic                 pixel_valid,
  output logic [DATA_SIZE-1:0] pixel_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start
);

  logic active0;
  logic hsync0;
  logic vsync0;
  logic origin0;
  logic flip_point;
  logic wrap;
  logic pending;
  logic flip_now;

  scanout_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .active0   (active0),
    .hsync0    (hsync0),
    .vsync0    (vsync0),
    .origin0   (origin0),
    .flip_point(flip_point),
    .wrap      (wrap)
  );

  // Raster order makes y*H_ACTIVE+x a plain running count of visible pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_addr <= '0;
    end else if (wrap) begin
      read_addr <= '0;
    end else if (active0) begin
      read_addr <= read_addr + ADDR_SIZE'(1);
    end else begin
      read_addr <= read_addr;
    end
  end

  // A request landing exactly on the flip point is served immediately,
  // so it never needs to be remembered.
  assign flip_now  = flip_point && (pending || frame_ready) && !rst;
  assign flip      = flip_now;
  assign swap_done = flip_now;

  // Remember one swap request until the next flip point; extras are absorbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (flip_now) begin
      pending <= 1'b0;
    end else if (frame_ready) begin
      pending <= 1'b1;
    end else begin
      pending <= pending;
    end
  end

  // Delay stage-0 timing by one cycle to line up with the SRAM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      pixel_valid <= active0;
      hsync       <= hsync0;
      vsync       <= vsync0;
      frame_start <= origin0;
    end
  end

  assign pixel_data = pixel_valid ? read_data : {DATA_SIZE{1'b0}};

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Self-checking bench for framebuffer_scanout against a frame-arithmetic model.
module tb_framebuffer_scanout;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_ready;
  logic [7:0] read_data;
  logic [7:0] read_addr;
  logic       flip;
  logic       swap_done;
  logic       pixel_valid;
  logic [7:0] pixel_data;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  framebuffer_scanout dut (
    .clk        (clk),
    .rst        (rst),
    .frame_ready(frame_ready),
    .read_data  (read_data),
    .read_addr  (read_addr),
    .flip       (flip),
    .swap_done  (swap_done),
    .pixel_valid(pixel_valid),
    .pixel_data (pixel_data),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // SRAM read channel: data one cycle after the address.
  logic [7:0] mem [256];
  always @(posedge clk) read_data <= mem[read_addr];

  int   n_cmp = 0;
  int   n_err = 0;
  int   k;        // cycles since reset release (0 = first cycle at (0,0))
  logic pend_m;   // model swap request

  // Model: a frame is 480 cycles; 24 cycles per line, 16x16 visible.
  function automatic int hpos(input int kk); return (kk % 480) % 24; endfunction
  function automatic int vpos(input int kk); return (kk % 480) / 24; endfunction
  function automatic bit act(input int kk); return hpos(kk) < 16 && vpos(kk) < 16; endfunction
  function automatic logic [7:0] addr_of(input int kk);
    int h;
    h = (hpos(kk) < 16) ? hpos(kk) : 16;
    if (vpos(kk) >= 16) return 8'h00;
    return 8'((vpos(kk) * 16 + h) % 256);
  endfunction
  function automatic bit flip_exp();
    return ((k % 480) == 384) && (pend_m || frame_ready);
  endfunction

  // Close the current cycle in the model and move to the next one.
  task automatic go(input logic fr);
    if (flip_exp()) pend_m = 1'b0;
    else if (frame_ready) pend_m = 1'b1;
    @(posedge clk);
    #1;
    k++;
    frame_ready = fr;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    frame_ready = 1'b0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    pend_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(3);
    n_cmp++;
    if ({pixel_valid, hsync, vsync, frame_start, flip, swap_done} !== 6'b011000) begin
      n_err++;
      $display("FAIL reset_ctl got=%b exp=%b", {pixel_valid, hsync, vsync, frame_start, flip, swap_done}, 6'b011000);
    end
    n_cmp++;
    if (pixel_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_pdata got=%h exp=00", pixel_data);
    end
    n_cmp++;
    if (read_addr !== 8'h00) begin
      n_err++;
      $display("FAIL reset_addr got=%h exp=00", read_addr);
    end
  endtask

  // Address-echo SRAM; two full frames checked cycle by cycle plus frame stats.
  task automatic test_raster();
    int pk, last_fs, n_fs, vcnt, vs_low;
    logic [3:0] exp_ctl;
    logic [7:0] exp_pd, last_pd;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    do_reset(2);
    last_fs = -1; n_fs = 0; vcnt = 0; vs_low = 0; last_pd = 8'h00;
    for (int i = 0; i < 962; i++) begin
      go(1'b0);
      pk = k - 1;
      exp_ctl = {act(pk), !(hpos(pk) >= 18 && hpos(pk) < 22), !(vpos(pk) >= 17 && vpos(pk) < 19), (pk % 480) == 0};
      exp_pd = act(pk) ? mem[addr_of(pk)] : 8'h00;
      n_cmp++;
      if ({pixel_valid, hsync, vsync, frame_start} !== exp_ctl) begin
        n_err++;
        $display("FAIL raster_ctl k=%0d got=%b exp=%b", k, {pixel_valid, hsync, vsync, frame_start}, exp_ctl);
      end
      n_cmp++;
      if (pixel_data !== exp_pd) begin
        n_err++;
        $display("FAIL raster_pdata k=%0d got=%h exp=%h", k, pixel_data, exp_pd);
      end
      n_cmp++;
      if (read_addr !== addr_of(k)) begin
        n_err++;
        $display("FAIL raster_addr k=%0d got=%h exp=%h", k, read_addr, addr_of(k));
      end
      n_cmp++;
      if ({flip, swap_done} !== 2'b00) begin
        n_err++;
        $display("FAIL raster_noflip k=%0d got=%b exp=00", k, {flip, swap_done});
      end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (k - last_fs != 480) begin
            n_err++;
            $display("FAIL frame_gap got=%0d exp=480", k - last_fs);
          end
          n_cmp++;
          if (vcnt != 256 || last_pd !== 8'hff) begin
            n_err++;
            $display("FAIL frame_pixels got=%0d/%h exp=256/ff", vcnt, last_pd);
          end
          n_cmp++;
          if (vs_low != 48) begin
            n_err++;
            $display("FAIL vsync_width got=%0d exp=48", vs_low);
          end
        end
        last_fs = k; n_fs++; vcnt = 0; vs_low = 0;
      end
      if (pixel_valid === 1'b1) begin vcnt++; last_pd = pixel_data; end
      if (vsync === 1'b0) vs_low++;
    end
    n_cmp++;
    if (n_fs != 3) begin
      n_err++;
      $display("FAIL frame_start_count got=%0d exp=3", n_fs);
    end
  endtask

  // Directed swap requests then random traffic, with random pixel content.
  task automatic test_swap();
    int flips[$];
    logic fr;
    logic [7:0] exp_pd;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    do_reset(1);
    for (int i = 0; i < 2880; i++) begin
      if (i < 1440) fr = ((k + 1) == 100) || ((k + 1) == 200) || ((k + 1) == 385);
      else fr = ($urandom_range(0, 59) == 0);
      go(fr);
      n_cmp++;
      if ({flip, swap_done} !== {flip_exp(), flip_exp()}) begin
        n_err++;
        $display("FAIL swap_flip k=%0d got=%b exp=%b", k, {flip, swap_done}, {flip_exp(), flip_exp()});
      end
      exp_pd = act(k - 1) ? mem[addr_of(k - 1)] : 8'h00;
      n_cmp++;
      if (pixel_data !== exp_pd) begin
        n_err++;
        $display("FAIL swap_pdata k=%0d got=%h exp=%h", k, pixel_data, exp_pd);
      end
      if (i < 1440 && flip === 1'b1) flips.push_back(k);
    end
    n_cmp++;
    if (flips.size() != 2 || flips[0] != 384 || flips[1] != 864) begin
      n_err++;
      $display("FAIL swap_directed got=%0d flips first=%0d exp=2 flips at 384,864", flips.size(), (flips.size() > 0) ? flips[0] : -1);
    end
  endtask

  // Request arriving exactly on the flip point is served at once, not kept.
  task automatic test_simultaneous();
    for (int g = 0; g < 480 && (k % 480) != 385; g++) go(1'b0);
    for (int g = 0; g < 480 && (k % 480) != 383; g++) go(1'b0);
    go(1'b1);
    n_cmp++;
    if ({flip, swap_done} !== 2'b11) begin
      n_err++;
      $display("FAIL simul_flip k=%0d got=%b exp=11", k, {flip, swap_done});
    end
    for (int i = 0; i < 481; i++) begin
      go(1'b0);
      n_cmp++;
      if ({flip, swap_done} !== 2'b00) begin
        n_err++;
        $display("FAIL simul_no_refire k=%0d got=%b exp=00", k, {flip, swap_done});
      end
    end
  endtask

  // Reset in the middle of active video with a request pending.
  task automatic test_mid_reset();
    for (int g = 0; g < 480 && (k % 480) != 51; g++) go(1'b0);
    go(1'b1);
    for (int g = 0; g < 480 && vpos(k) != 5; g++) go(1'b0);
    do_reset(1);
    n_cmp++;
    if ({pixel_valid, hsync, vsync, frame_start, flip, swap_done, pixel_data, read_addr} !== {6'b011000, 8'h00, 8'h00}) begin
      n_err++;
      $display("FAIL midreset_vals got=%b %h %h", {pixel_valid, hsync, vsync, frame_start, flip, swap_done}, pixel_data, read_addr);
    end
    for (int i = 0; i < 481; i++) begin
      go(1'b0);
      n_cmp++;
      if ({flip, swap_done} !== 2'b00) begin
        n_err++;
        $display("FAIL midreset_noflip k=%0d got=%b exp=00", k, {flip, swap_done});
      end
      n_cmp++;
      if (read_addr !== addr_of(k) || pixel_valid !== act(k - 1)) begin
        n_err++;
        $display("FAIL midreset_scan k=%0d got=%h/%b exp=%h/%b", k, read_addr, pixel_valid, addr_of(k), act(k - 1));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    frame_ready = 1'b0;
    pend_m = 1'b0;
    k = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_raster();
    test_swap();
    test_simultaneous();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
- Downstream consumer of the double-buffered pixel SRAM.
- Generates raster timing and drives the SRAM read address in raster order, then re-aligns sync/valid with the 1-cycle SRAM read latency to stream pixels to the display.
- Owns the buffer-swap handshake: a renderer request is converted into a single `flip` pulse issued only in vertical blanking, so a frame never tears.

Parameters:
- H_ACTIVE, 16, visible pixels per line
- H_FRONT, 2, horizontal front porch (cycles)
- H_SYNC, 4, hsync pulse width (cycles)
- H_BACK, 2, horizontal back porch (cycles)
- V_ACTIVE, 16, visible lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 1, vertical back porch (lines)
- ADDR_SIZE, 8, SRAM address width; must satisfy H_ACTIVE*V_ACTIVE <= 2^ADDR_SIZE
- DATA_SIZE, 8, pixel width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frame_ready  in  1  renderer pulse: back buffer complete, request swap
- read_data  in  DATA_SIZE  SRAM read-channel data; valid 1 cycle after `read_addr`
- read_addr  out  ADDR_SIZE  SRAM read-channel address
- flip  out  1  one-cycle swap pulse to the SRAM
- swap_done  out  1  one-cycle ack to renderer, coincident with `flip`
- pixel_valid  out  1  `pixel_data` is a visible pixel
- pixel_data  out  DATA_SIZE  pixel to display; 0 when `pixel_valid`=0
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_start  out  1  one-cycle pulse aligned with the first valid pixel of a frame

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters (24); V_TOTAL = sum of the four V_* parameters (20).
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. On wrap, v_cnt increments, wrapping V_TOTAL-1 to 0.
- Stage 0 (counter cycle):
  - active0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync0 low when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync0 low when V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC.
- Address counter:
  - `read_addr` is a register holding the address of the current stage-0 position.
  - Increments by 1 on each active0 cycle. Holds during blanking.
  - Cleared to 0 on the cycle (h_cnt,v_cnt) wraps to (0,0).
  - No multiplier; address = y*H_ACTIVE + x is implied by raster order.
- Stage 1 (output):
  - `pixel_valid`, `hsync`, `vsync`, `frame_start` are stage-0 values registered once, so they align with `read_data`.
  - pixel_data = pixel_valid ? read_data : 0.
  - Total latency from counter position to pixel output: 1 cycle.
- Swap handshake:
  - `pending` is set by `frame_ready`. Further `frame_ready` pulses while pending are absorbed with no effect.
  - Flip point: the cycle h_cnt==0 && v_cnt==V_ACTIVE, i.e. the first blanking line.
  - At the flip point with pending (or with `frame_ready` high that same cycle): assert `flip`=1 and `swap_done`=1 for exactly that cycle, and clear `pending`.
  - At most one flip per frame. A request arriving after the flip point waits for the next frame.
- Reset (at any time, including mid-frame):
  - h_cnt=v_cnt=0, read_addr=0, pending=0, flip=0, swap_done=0.
  - pixel_valid=0, pixel_data=0, hsync=1, vsync=1, frame_start=0.
  - Scan restarts at (0,0) on the first cycle after `rst` deasserts. The first `pixel_valid` appears 1 cycle later.
- No backpressure: the display consumes one pixel per clock unconditionally.

Decomposition:
- Package scanout_pkg:
  - Default timing localparams.
  - Derived H_TOTAL/V_TOTAL computation function.
  - Typedef scan_pos_t {h_cnt, v_cnt}.
  - Sync polarity constant (active-low).
- One sub-module, scanout_timing_gen:
  - Contents: h/v counters, active0/hsync0/vsync0, flip-point strobe.
  - The top level adds the address counter, swap handshake and output pipeline.

Test Plan:
- Reset release, defaults, `read_data` = address echo:
  - `pixel_valid` first high 1 cycle after reset release, with pixel_data=0.
  - 16 consecutive valid pixels carry 0..15, then 8 invalid cycles.
  - Line 2 carries 16..31.
- Full frame: count cycles between `frame_start` pulses.
  - Required gap: 480 cycles.
  - 256 valid pixels, last pixel_data=255.
  - `read_addr` back to 0 at wrap.
- Sync timing:
  - `hsync` low for 4 cycles starting 18 cycles after the first valid pixel of a line.
  - `vsync` low for exactly 48 cycles (2 lines) per frame.
- Swap handshake:
  - `frame_ready` pulse mid-active-region gives one `flip` + `swap_done` pulse at v_cnt=16, h_cnt=0.
  - A second `frame_ready` before that point gives no extra flip.
  - A pulse 1 cycle after the flip point flips in the next frame.
- Simultaneous: `frame_ready` high exactly on the flip-point cycle → `flip` in that same cycle, `pending` stays 0.
- Mid-frame reset:
  - Assert `rst` for 1 cycle at v_cnt=5 with `pending` set.
  - All outputs return to reset values, no `flip` at the next flip point, and the scan restarts at address 0.
